crossbar_ctrl_sequencer: RTL

//   Drives the 5-bit control input of the 4x4 4-bit crossbar.

---
 rtl/crossbar_ctrl_sequencer_if.sv | 29 ++
 rtl/crossbar_ctrl_sequencer.sv | 117 +++++++++++
 2 files changed

// File: rtl/crossbar_ctrl_sequencer_if.sv
// Host-side bus of the crossbar control sequencer.
// master: host (drives config/commit/sweep requests, observes status)
// slave : sequencer (owns control, pending, busy, sweep_done, cfg_ready)
interface crossbar_ctrl_sequencer_if #(
  parameter int unsigned CTRL_W  = 5,
  parameter int unsigned DWELL_W = 8
);
  logic               cfg_valid;
  logic               cfg_ready;
  logic [CTRL_W-1:0]  cfg_data;
  logic               commit;
  logic               sweep_start;
  logic [DWELL_W-1:0] sweep_dwell;
  logic               sweep_abort;
  logic [CTRL_W-1:0]  control;
  logic               pending;
  logic               busy;
  logic               sweep_done;

  modport master (
    output cfg_valid, cfg_data, commit, sweep_start, sweep_dwell, sweep_abort,
    input  cfg_ready, control, pending, busy, sweep_done
  );

  modport slave (
    input  cfg_valid, cfg_data, commit, sweep_start, sweep_dwell, sweep_abort,
    output cfg_ready, control, pending, busy, sweep_done
  );
endinterface

// File: rtl/crossbar_ctrl_sequencer.sv
// Drives the control word of the 4x4 crossbar.
// A valid/ready config channel loads a shadow word; commit copies the shadow
// to the live control register in one cycle. Sweep mode steps control through
// every code 0..2^CTRL_W-1, holding each for a programmable dwell.
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   bus    - slave side of crossbar_ctrl_sequencer_if (config, commit, sweep
//            control in; control, pending, busy, sweep_done, cfg_ready out)
module crossbar_ctrl_sequencer #(
  parameter int unsigned CTRL_W  = 5,
  parameter int unsigned DWELL_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  crossbar_ctrl_sequencer_if.slave bus
);

  localparam logic [CTRL_W-1:0] CODE_LAST = '1;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } state_e;

  state_e             state_q;
  logic [CTRL_W-1:0]  control_q;
  logic [CTRL_W-1:0]  shadow_q;
  logic               pending_q;
  logic               busy_q;
  logic               done_q;
  logic [DWELL_W-1:0] dwell_q;
  logic [DWELL_W-1:0] dwell_cnt_q;

  logic               cfg_accept_c;
  logic [DWELL_W-1:0] dwell_load_d;

  // Ready depends only on state so the host never sees a combinational loop.
  assign bus.cfg_ready = (state_q == ST_IDLE);
  assign cfg_accept_c  = bus.cfg_valid & (state_q == ST_IDLE);

  // A dwell of zero is treated as one cycle per code.
  assign dwell_load_d  = (bus.sweep_dwell == '0) ? DWELL_W'(1) : bus.sweep_dwell;

  // Sequencer state and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      control_q   <= '0;
      shadow_q    <= '0;
      pending_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dwell_q     <= DWELL_W'(1);
      dwell_cnt_q <= DWELL_W'(1);
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (bus.sweep_start) begin
            // Sweep wins over commit; a concurrent config still lands in shadow.
            state_q     <= ST_SWEEP;
            busy_q      <= 1'b1;
            control_q   <= '0;
            dwell_q     <= dwell_load_d;
            dwell_cnt_q <= dwell_load_d;
            if (cfg_accept_c) begin
              shadow_q  <= bus.cfg_data;
              pending_q <= 1'b1;
            end
          end else if (bus.commit && cfg_accept_c) begin
            // Accept and commit together forward the incoming word directly.
            shadow_q  <= bus.cfg_data;
            control_q <= bus.cfg_data;
            pending_q <= 1'b0;
          end else if (bus.commit && pending_q) begin
            control_q <= shadow_q;
            pending_q <= 1'b0;
          end else if (cfg_accept_c) begin
            shadow_q  <= bus.cfg_data;
            pending_q <= 1'b1;
          end
        end

        ST_SWEEP: begin
          if (bus.sweep_abort) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else if (dwell_cnt_q == DWELL_W'(1)) begin
            if (control_q == CODE_LAST) begin
              // Final code fully held: stop without wrapping back to zero.
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              control_q   <= control_q + CTRL_W'(1);
              dwell_cnt_q <= dwell_q;
            end
          end else begin
            dwell_cnt_q <= dwell_cnt_q - DWELL_W'(1);
          end
        end

        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.control    = control_q;
  assign bus.pending    = pending_q;
  assign bus.busy       = busy_q;
  assign bus.sweep_done = done_q;

endmodule
